// File: rtl/seq_mul_pkg.sv
// rtl/seq_mul_pkg.sv - shared types, magnitude helper and config checks for seq_mul_pipe
package seq_mul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_t;

  // Widest operand the magnitude helper handles; operands are zero-extended into it.
  localparam int MAX_W = 64;

  function automatic bit cfg_ok(input int width, input int unroll);
    return (width >= 2) && (width <= MAX_W) && (unroll >= 1) &&
           ((unroll & (unroll - 1)) == 0) && ((width % unroll) == 0);
  endfunction

  // Magnitude is returned as an unsigned W-bit value, so -2^(W-1) maps cleanly to 2^(W-1).
  function automatic logic [MAX_W-1:0] abs_w(input logic [MAX_W-1:0] val, input int width,
                                             input logic is_signed);
    logic [MAX_W-1:0] mask;
    logic             neg;
    mask = (width >= MAX_W) ? '1 : ((MAX_W'(1) << width) - MAX_W'(1));
    neg  = is_signed & val[$clog2(MAX_W)'(width - 1)];
    return neg ? ((~val + MAX_W'(1)) & mask) : (val & mask);
  endfunction

endpackage

// File: rtl/seq_mul_pp_slice.sv
// rtl/seq_mul_pp_slice.sv - partial sum of UNROLL shifted multiplicand copies for one BUSY cycle
module seq_mul_pp_slice #(
  parameter int WIDTH  = 8,
  parameter int UNROLL = 1,
  parameter int SHW    = 4
) (
  input  logic [WIDTH-1:0]   a_mag,
  input  logic [UNROLL-1:0]  b_bits,
  input  logic [SHW-1:0]     shift,
  output logic [2*WIDTH-1:0] partial
);

  always_comb begin
    partial = '0;
    for (int k = 0; k < UNROLL; k++) begin
      partial = partial +
                ({{WIDTH{1'b0}}, a_mag & {WIDTH{b_bits[k]}}} << (shift + SHW'(k)));
    end
  end

endmodule

// File: rtl/seq_mul_pipe.sv
// rtl/seq_mul_pipe.sv - multi-cycle shift-and-add multiplier, signed/unsigned, valid/ready on both sides
module seq_mul_pipe
  import seq_mul_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int UNROLL = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);

  localparam int N   = WIDTH / UNROLL;
  localparam int CW  = $clog2(N + 1);
  localparam int SHW = $clog2(2 * WIDTH);

  if (!cfg_ok(WIDTH, UNROLL)) begin : g_bad_cfg
    $error("seq_mul_pipe: WIDTH must be >= 2 and UNROLL a power of two dividing WIDTH");
  end

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, b_q;
  logic               sign_q;
  logic [2*WIDTH-1:0] acc_q, acc_sum, partial, product_q;
  logic [CW-1:0]      cnt_q;
  logic [SHW-1:0]     shift_q;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic               last_iter;

  assign abs_a     = WIDTH'(abs_w(MAX_W'(multiplicand), WIDTH, signed_mode));
  assign abs_b     = WIDTH'(abs_w(MAX_W'(multiplier), WIDTH, signed_mode));
  assign acc_sum   = acc_q + partial;
  assign last_iter = (cnt_q == CW'(1));

  seq_mul_pp_slice #(
    .WIDTH (WIDTH),
    .UNROLL(UNROLL),
    .SHW   (SHW)
  ) u_pp_slice (
    .a_mag  (a_q),
    .b_bits (b_q[UNROLL-1:0]),
    .shift  (shift_q),
    .partial(partial)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ST_BUSY;
      end
      ST_BUSY: if (last_iter) state_d = ST_DONE;
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      sign_q    <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      shift_q   <= '0;
      product_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (in_valid) begin
          a_q     <= abs_a;
          b_q     <= abs_b;
          sign_q  <= signed_mode & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
          acc_q   <= '0;
          cnt_q   <= CW'(N);
          shift_q <= '0;
        end
        ST_BUSY: begin
          acc_q   <= acc_sum;
          b_q     <= b_q >> UNROLL;
          shift_q <= shift_q + SHW'(UNROLL);
          cnt_q   <= cnt_q - CW'(1);
          // Sign fix-up folds into the final iteration so DONE holds a stable result.
          if (last_iter) product_q <= sign_q ? -acc_sum : acc_sum;
        end
        default: ;
      endcase
    end
  end

  assign product = product_q;

endmodule

// File: tb/tb_seq_mul_pipe.sv
// tb/tb_seq_mul_pipe.sv - directed-vector and random self-checking bench for seq_mul_pipe
module tb_seq_mul_pipe;

  logic        clk, rst_n;
  logic        iv8, ir8, sm8, ov8, or8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;
  logic        iv16, ir16, sm16, ov16, or16;
  logic [15:0] a16, b16;
  logic [31:0] p16;

  int checks   = 0;
  int failures = 0;

  seq_mul_pipe #(.WIDTH(8), .UNROLL(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
    .multiplicand(a8), .multiplier(b8), .signed_mode(sm8),
    .out_valid(ov8), .out_ready(or8), .product(p8)
  );

  seq_mul_pipe #(.WIDTH(16), .UNROLL(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
    .multiplicand(a16), .multiplier(b16), .signed_mode(sm16),
    .out_valid(ov16), .out_ready(or16), .product(p16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          wide;
    logic [15:0] a;
    logic [15:0] b;
    logic        sgn;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Runs one transaction; hold>0 stalls out_ready in DONE and sprays in_valid while busy.
  task automatic run(input bit wide, input logic [15:0] a, input logic [15:0] b,
                     input logic s, input int hold, output logic [31:0] prod,
                     output int lat);
    @(negedge clk);
    if (wide) begin a16 = a; b16 = b; sm16 = s; iv16 = 1'b1; or16 = (hold == 0); end
    else      begin a8 = a[7:0]; b8 = b[7:0]; sm8 = s; iv8 = 1'b1; or8 = (hold == 0); end
    chk("in_ready_before_accept", {31'b0, wide ? ir16 : ir8}, 32'd1);
    @(negedge clk);
    if (hold > 0) begin
      if (wide) begin a16 = 16'h1234; b16 = 16'h4321; end
      else      begin a8 = 8'hAA; b8 = 8'h55; end
      chk("in_ready_busy", {31'b0, wide ? ir16 : ir8}, 32'd0);
    end else begin
      if (wide) iv16 = 1'b0; else iv8 = 1'b0;
    end
    lat = 1;
    while (!(wide ? ov16 : ov8) && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    prod = wide ? p16 : {16'b0, p8};
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_out_valid", {31'b0, wide ? ov16 : ov8}, 32'd1);
      chk("hold_product", wide ? p16 : {16'b0, p8}, prod);
      chk("hold_in_ready", {31'b0, wide ? ir16 : ir8}, 32'd0);
    end
    if (wide) begin iv16 = 1'b0; or16 = 1'b1; end
    else      begin iv8 = 1'b0; or8 = 1'b1; end
    @(negedge clk);
    chk("out_valid_one_cycle", {31'b0, wide ? ov16 : ov8}, 32'd0);
    chk("in_ready_after_done", {31'b0, wide ? ir16 : ir8}, 32'd1);
  endtask

  initial begin
    logic [31:0]        prod;
    int                 lat;
    int                 ov_seen;
    logic [15:0]        ra, rb;
    logic               rs;
    logic signed [31:0] sa, sb;
    logic [31:0]        exp;

    vecs[0]  = '{1'b0, 16'd13,    16'd11,    1'b0, 32'h0000_008F};
    vecs[1]  = '{1'b0, 16'd255,   16'd255,   1'b0, 32'h0000_FE01};
    vecs[2]  = '{1'b0, 16'h00FD,  16'd5,     1'b1, 32'h0000_FFF1};
    vecs[3]  = '{1'b0, 16'h0080,  16'h0080,  1'b1, 32'h0000_4000};
    vecs[4]  = '{1'b0, 16'h0080,  16'h007F,  1'b1, 32'h0000_C080};
    vecs[5]  = '{1'b0, 16'd0,     16'd255,   1'b0, 32'h0000_0000};
    vecs[6]  = '{1'b0, 16'h00FF,  16'h00FF,  1'b1, 32'h0000_0001};
    vecs[7]  = '{1'b0, 16'h00FD,  16'd5,     1'b0, 32'h0000_04F1};
    vecs[8]  = '{1'b1, 16'hFC18,  16'd300,   1'b1, 32'hFFFB_6C20};
    vecs[9]  = '{1'b1, 16'hFFFF,  16'hFFFF,  1'b0, 32'hFFFE_0001};
    vecs[10] = '{1'b1, 16'h8000,  16'h8000,  1'b1, 32'h4000_0000};
    vecs[11] = '{1'b1, 16'h7FFF,  16'h8000,  1'b1, 32'hC000_8000};

    rst_n = 1'b0;
    iv8 = 1'b0; sm8 = 1'b0; or8 = 1'b1; a8 = '0; b8 = '0;
    iv16 = 1'b0; sm16 = 1'b0; or16 = 1'b1; a16 = '0; b16 = '0;
    repeat (2) @(negedge clk);
    chk("reset_in_ready8",  {31'b0, ir8},  32'd1);
    chk("reset_out_valid8", {31'b0, ov8},  32'd0);
    chk("reset_product8",   {16'b0, p8},   32'd0);
    chk("reset_in_ready16", {31'b0, ir16}, 32'd1);
    chk("reset_out_valid16",{31'b0, ov16}, 32'd0);
    chk("reset_product16",  p16,           32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run(vecs[i].wide, vecs[i].a, vecs[i].b, vecs[i].sgn, 0, prod, lat);
      chk($sformatf("vec%0d_product", i), prod, vecs[i].exp);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].wide ? 32'd5 : 32'd9);
    end

    run(1'b0, 16'd25, 16'd10, 1'b0, 5, prod, lat);
    chk("stall_product", prod, 32'h0000_00FA);
    chk("stall_latency", lat, 32'd9);

    // Abort a transaction in its fourth BUSY cycle.
    @(negedge clk);
    a8 = 8'd7; b8 = 8'd9; sm8 = 1'b0; iv8 = 1'b1;
    @(negedge clk);
    iv8 = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset_in_ready8", {31'b0, ir8}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_in_ready8",  {31'b0, ir8}, 32'd1);
    chk("async_rst_out_valid8", {31'b0, ov8}, 32'd0);
    chk("async_rst_product8",   {16'b0, p8},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ov_seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (ov8) ov_seen++;
    end
    chk("no_spurious_out_valid", ov_seen, 32'd0);
    run(1'b0, 16'd2, 16'd3, 1'b0, 0, prod, lat);
    chk("post_reset_product", prod, 32'h0000_0006);
    chk("post_reset_latency", lat, 32'd9);

    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = i[0];
      sa = rs ? {{16{ra[15]}}, ra} : {16'b0, ra};
      sb = rs ? {{16{rb[15]}}, rb} : {16'b0, rb};
      exp = 32'(sa * sb);
      run(1'b1, ra, rb, rs, 0, prod, lat);
      chk($sformatf("rand16_%0d a=%h b=%h s=%0d", i, ra, rb, rs), prod, exp);
    end

    for (int i = 0; i < 200; i++) begin
      ra = {8'b0, 8'($urandom)};
      rb = {8'b0, 8'($urandom)};
      rs = i[0];
      sa = rs ? {{24{ra[7]}}, ra[7:0]} : {24'b0, ra[7:0]};
      sb = rs ? {{24{rb[7]}}, rb[7:0]} : {24'b0, rb[7:0]};
      exp = {16'b0, 16'(sa * sb)};
      run(1'b0, ra, rb, rs, 0, prod, lat);
      chk($sformatf("rand8_%0d a=%h b=%h s=%0d", i, ra[7:0], rb[7:0], rs), prod, exp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_mul_pipe.md
# seq_mul_pipe

Parametrised, multi-cycle shift-and-add multiplier with signed/unsigned mode and valid/ready handshakes on both sides. It is the sequential successor to the team's combinational 8×8 array multiplier. It trades area for latency by retiring `UNROLL` multiplier bits per clock. It sits in datapaths where a full array multiplier is too large and throughput of one result per `WIDTH/UNROLL + 2` cycles is acceptable.

## Interface
- `WIDTH`, 8: operand width; ≥ 2.
- `UNROLL`, 1: multiplier bits consumed per BUSY cycle; power of two dividing `WIDTH`. Any other value is an elaboration-time error.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: operands valid.
- `in_ready` output 1: block can accept operands.
- `multiplicand` input WIDTH: operand A.
- `multiplier` input WIDTH: operand B.
- `signed_mode` input 1: 1 = both operands two's complement; 0 = both unsigned. Sampled with the operands.
- `out_valid` output 1: `product` valid.
- `out_ready` input 1: consumer accepts `product`.
- `product` output 2*WIDTH: A×B, full precision.

## Operation
- FSM states: IDLE, BUSY, DONE.
- **IDLE**
  - `in_ready`=1, `out_valid`=0.
  - On `in_valid && in_ready`: register |A|, |B|, result sign, and a cleared 2W-bit accumulator.
  - Load iteration counter N = `WIDTH/UNROLL`; go to BUSY.
- **Absolute values and sign**
  - Unsigned mode: |A|=A, |B|=B, sign=0.
  - Signed mode: magnitude is taken as a W-bit unsigned value, so −2^(W−1) maps to 2^(W−1) and no overflow occurs. sign = A[W−1]^B[W−1].
- **BUSY**
  - Each cycle: accumulator += sum over k<UNROLL of (|A| & {W{Bk}}) << (shift+k). Bk are the next UNROLL low bits of the shifting |B|.
  - Shift advances by UNROLL; counter decrements.
  - Inputs are ignored; `in_ready`=0.
  - On the last iteration: `product` is registered as sign ? −acc : acc (2W-bit two's complement). Go to DONE.
- **DONE**
  - `out_valid`=1; `product` and `out_valid` held stable until `out_ready`.
  - On `out_ready`: go to IDLE.
  - `in_ready`=0 in DONE; no overlap between transactions.
- Width rule: every result, including (−2^(W−1))², fits exactly in 2W bits; no saturation or truncation.
- Zero operand: still takes the full N iterations. There is no early-out, so latency is deterministic.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `product`=0, state=IDLE.
- Reset asserts asynchronously at any point, including mid-BUSY or in DONE with `out_valid` high. The transaction is discarded and no output pulse is produced.
- Latency:
  - Handshake on edge t.
  - BUSY occupies edges t+1 … t+N.
  - `out_valid` is high after edge t+N, i.e. N+1 cycles after acceptance.
- Throughput: at best one result per N+2 cycles (accept, N busy, one DONE cycle with `out_ready`=1).
- `out_ready` is ignored outside DONE. `in_valid` is ignored outside IDLE.
- `product` changes only on entry to DONE, or to 0 on reset.

## Structure
- Shared package `seq_mul_pkg`:
  - state enum (IDLE/BUSY/DONE);
  - function `abs_w` (W-bit magnitude of a W-bit value given a signed flag);
  - elaboration checks for `WIDTH`/`UNROLL`.
- Sub-module `seq_mul_pp_slice`: combinational. Takes |A|, UNROLL multiplier bits and shift, and returns the 2W-bit partial sum for one BUSY cycle.
- Top holds FSM, counter, operand and accumulator registers, and the sign fix-up.

## Test plan
- WIDTH=8, UNROLL=1, unsigned, A=13, B=11, `out_ready`=1 → `product`=0x008F. `out_valid` rises exactly 9 cycles after the handshake and stays high for 1 cycle.
- Unsigned A=255, B=255 → 0xFE01. Signed A=0xFD (−3), B=5 → 0xFFF1 (−15).
- Signed A=B=0x80 (−128) → 0x4000. Signed A=0x80, B=0x7F → 0xC080 (−16256).
- Hold `out_ready`=0 for 5 cycles in DONE → `product`/`out_valid` stable, `in_ready`=0. `in_valid` pulses during BUSY/DONE are not captured.
- Assert `rst_n`=0 at BUSY cycle 4 → outputs reset immediately. After release, a new A=2, B=3 transaction yields 0x0006 with no spurious `out_valid`.
- WIDTH=16, UNROLL=4, signed, A=−1000, B=300 → 0xFFFB_6C20. Latency 5 cycles. Random 1000-vector sweep against a reference model in both modes.
